ifm_chunk_bank_ring: RTL and testbench

Multi-bank IFM chunk buffer between the IFM loader and the compute units (CUs). It generalises the two-bank ping-pong chunk store to BANK_NUM banks filled in ring order. The write side has a valid/ready handshake with an internal beat counter. Each CU advances its own read-bank pointer independently, and a bank is recycled only after every CU has released it. Each CU gets a shifted sparsemap window and a nonzero-data lookup per cycle, plus a per-CU valid flag.

---
 rtl/ifm_chunk_bank_ring.sv | 190 +++++++++++++++++++
 tb/tb_ifm_chunk_bank_ring.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_chunk_bank_ring.sv
// Ring of BANK_NUM IFM chunk banks: loader fills banks in order, each CU walks its own
// read pointer, and a bank returns to FREE once every CU has released it.
module ifm_chunk_bank_ring #(
   parameter int BANK_NUM        = 4,
   parameter int BUS_SIZE        = 32,
   parameter int MEM_SIZE        = 128,
   parameter int PREFIX_SUM_SIZE = 8,
   parameter int CU_NUM          = 4
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic                                            flush_i,
   input  logic                                            wr_valid_i,
   output logic                                            wr_ready_o,
   input  logic [BUS_SIZE-1:0]                             wr_sparsemap_i,
   input  logic [BUS_SIZE*8-1:0]                           wr_nonzero_data_i,
   output logic [$clog2(BANK_NUM)-1:0]                     wr_bank_o,
   output logic [$clog2(BANK_NUM):0]                       full_cnt_o,
   input  logic [$clog2(PREFIX_SUM_SIZE)-1:0]              shift_left_i,
   input  logic [CU_NUM-1:0]                               pri_enc_last_i,
   input  logic [CU_NUM*$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0] rd_sparsemap_addr_i,
   output logic [CU_NUM*PREFIX_SUM_SIZE-1:0]               rd_sparsemap_o,
   input  logic [CU_NUM*($clog2(MEM_SIZE)+1)-1:0]          rd_addr_i,
   output logic [CU_NUM*8-1:0]                             rd_data_o,
   output logic [CU_NUM-1:0]                               rd_valid_o,
   output logic [CU_NUM*$clog2(BANK_NUM)-1:0]              rd_bank_o
);
   localparam int BEATS   = MEM_SIZE / BUS_SIZE;
   localparam int SEGS    = MEM_SIZE / PREFIX_SUM_SIZE;
   localparam int BANK_W  = $clog2(BANK_NUM);
   localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SEG_W   = $clog2(SEGS);
   localparam int SHIFT_W = $clog2(PREFIX_SUM_SIZE);
   localparam int BYTE_W  = $clog2(BUS_SIZE);
   localparam int ENTRY_W = $clog2(MEM_SIZE);
   localparam int ADDR_W  = ENTRY_W + 1;

   localparam logic [1:0] ST_FREE    = 2'd0;
   localparam logic [1:0] ST_FILLING = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   logic [BEATS-1:0][BUS_SIZE-1:0]   r_smap [BANK_NUM];
   logic [BEATS-1:0][BUS_SIZE*8-1:0] r_data [BANK_NUM];

   logic [BANK_NUM-1:0][1:0]        r_state,    w_state_next;
   logic [BANK_NUM-1:0][CU_NUM-1:0] r_consumed, w_consumed_next;
   logic [CU_NUM-1:0][BANK_W-1:0]   r_rd_ptr,   w_rd_ptr_next;
   logic [BANK_W-1:0]               r_wr_ptr,   w_wr_ptr_next;
   logic [BEAT_W-1:0]               r_beat,     w_beat_next;

   logic [BANK_NUM-1:0][CU_NUM-1:0] w_rel_mask;
   logic [CU_NUM-1:0]               w_release;
   logic                            w_accept;
   logic                            w_last_beat;
   logic [BANK_W:0]                 w_full_cnt;

   assign wr_ready_o  = (r_state[r_wr_ptr] == ST_FREE) || (r_state[r_wr_ptr] == ST_FILLING);
   assign w_accept    = wr_valid_i && wr_ready_o;
   assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

   // Chunk storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_smap[r_wr_ptr][r_beat] <= wr_sparsemap_i;
         r_data[r_wr_ptr][r_beat] <= wr_nonzero_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= '0;
         r_consumed <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_beat     <= '0;
      end else if (flush_i) begin
         r_state    <= '0;
         r_consumed <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_beat     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_consumed <= w_consumed_next;
         r_rd_ptr   <= w_rd_ptr_next;
         r_wr_ptr   <= w_wr_ptr_next;
         r_beat     <= w_beat_next;
      end
   end

   always_comb begin
      w_rel_mask = '0;
      for (int b = 0; b < BANK_NUM; b++) begin
         for (int c = 0; c < CU_NUM; c++) begin
            if (w_release[c] && (r_rd_ptr[c] == BANK_W'(b))) begin
               w_rel_mask[b][c] = 1'b1;
            end
         end
      end
   end

   // A bank can only be freed while FULL and only written while FREE/FILLING,
   // so the release and write updates never touch the same bank.
   always_comb begin
      w_state_next    = r_state;
      w_consumed_next = r_consumed;
      w_rd_ptr_next   = r_rd_ptr;
      w_wr_ptr_next   = r_wr_ptr;
      w_beat_next     = r_beat;
      for (int c = 0; c < CU_NUM; c++) begin
         if (w_release[c]) begin
            w_rd_ptr_next[c] = r_rd_ptr[c] + 1'b1;
         end
      end
      for (int b = 0; b < BANK_NUM; b++) begin
         if ((r_state[b] == ST_FULL) && (&(r_consumed[b] | w_rel_mask[b]))) begin
            w_state_next[b]    = ST_FREE;
            w_consumed_next[b] = '0;
         end else begin
            w_consumed_next[b] = r_consumed[b] | w_rel_mask[b];
         end
      end
      if (w_accept) begin
         if (w_last_beat) begin
            w_state_next[r_wr_ptr] = ST_FULL;
            w_beat_next            = '0;
            w_wr_ptr_next          = r_wr_ptr + 1'b1;
         end else begin
            w_state_next[r_wr_ptr] = ST_FILLING;
            w_beat_next            = r_beat + 1'b1;
         end
      end
   end

   always_comb begin
      w_full_cnt = '0;
      for (int b = 0; b < BANK_NUM; b++) begin
         if (r_state[b] == ST_FULL) begin
            w_full_cnt = w_full_cnt + 1'b1;
         end
      end
   end

   assign full_cnt_o = w_full_cnt;
   assign wr_bank_o  = r_wr_ptr;
   assign rd_bank_o  = r_rd_ptr;

   genvar gi;
   generate
      for (gi = 0; gi < CU_NUM; gi++) begin : g_cu
         logic [BANK_W-1:0]            w_bank;
         logic                         w_valid;
         logic [MEM_SIZE-1:0]          w_smap_flat;
         logic [SEG_W-1:0]             w_seg;
         logic [SEG_W-1:0]             w_seg_nxt;
         logic [PREFIX_SUM_SIZE-1:0]   w_lo;
         logic [PREFIX_SUM_SIZE-1:0]   w_hi;
         logic [2*PREFIX_SUM_SIZE-1:0] w_win;
         logic [PREFIX_SUM_SIZE-1:0]   w_win_sh;
         logic [ADDR_W-1:0]            w_addr;
         logic [ENTRY_W-1:0]           w_entry;
         logic                         w_in_range;
         logic [7:0]                   w_byte;

         assign w_bank      = r_rd_ptr[gi];
         assign w_valid     = (r_state[w_bank] == ST_FULL);
         assign w_smap_flat = r_smap[w_bank];
         assign w_seg       = rd_sparsemap_addr_i[gi*SEG_W +: SEG_W];
         assign w_seg_nxt   = w_seg + 1'b1;

         // Low half is always segment s; the next segment only joins for interior segments.
         assign w_lo  = w_smap_flat[{w_seg, {SHIFT_W{1'b0}}} +: PREFIX_SUM_SIZE];
         assign w_hi  = ((w_seg != '0) && (w_seg != SEG_W'(SEGS - 1))) ?
                        w_smap_flat[{w_seg_nxt, {SHIFT_W{1'b0}}} +: PREFIX_SUM_SIZE] : '0;
         assign w_win = {w_hi, w_lo};
         assign w_win_sh = PREFIX_SUM_SIZE'(w_win << shift_left_i);

         assign w_addr     = rd_addr_i[gi*ADDR_W +: ADDR_W];
         assign w_in_range = (w_addr != '0) && (w_addr <= ADDR_W'(MEM_SIZE));
         assign w_entry    = ENTRY_W'(w_addr - 1'b1);
         assign w_byte     = r_data[w_bank][w_entry[ENTRY_W-1:BYTE_W]][{w_entry[BYTE_W-1:0], 3'b000} +: 8];

         assign rd_valid_o[gi] = w_valid;
         assign rd_sparsemap_o[gi*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE] = w_valid ? w_win_sh : '0;
         assign rd_data_o[gi*8 +: 8] = (w_valid && w_in_range) ? w_byte : '0;
         assign w_release[gi] = w_valid && (w_seg == SEG_W'(SEGS - 1)) && pri_enc_last_i[gi];
      end
   endgenerate

endmodule

// File: tb/tb_ifm_chunk_bank_ring.sv
// Directed bench for ifm_chunk_bank_ring: fill/read, window shifts, ring-full, releases,
// same-cycle release/write, flush and mid-fill reset.
module tb_ifm_chunk_bank_ring;
   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         flush_i;
   logic         wr_valid_i;
   logic         wr_ready_o;
   logic [31:0]  wr_sparsemap_i;
   logic [255:0] wr_nonzero_data_i;
   logic [1:0]   wr_bank_o;
   logic [2:0]   full_cnt_o;
   logic [2:0]   shift_left_i;
   logic [3:0]   pri_enc_last_i;
   logic [15:0]  rd_sparsemap_addr_i;
   logic [31:0]  rd_sparsemap_o;
   logic [31:0]  rd_addr_i;
   logic [31:0]  rd_data_o;
   logic [3:0]   rd_valid_o;
   logic [7:0]   rd_bank_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] smap_pat [4] = '{32'h11FF3CA5, 32'h22222222, 32'h33333333, 32'hB6444444};
   int          win_shift [4]    = '{3, 4, 1, 0};
   int          win_s     [4][4] = '{'{0, 1, 2, 15}, '{1, 15, 3, 4}, '{15, 2, 14, 0}, '{3, 8, 13, 1}};
   logic [7:0]  win_exp   [4][4] = '{'{8'h28, 8'hE0, 8'hF8, 8'hB0},
                                     '{8'hC0, 8'h60, 8'h10, 8'h20},
                                     '{8'h6C, 8'hFE, 8'h88, 8'h4A},
                                     '{8'h11, 8'h33, 8'h44, 8'h3C}};

   ifm_chunk_bank_ring #(
      .BANK_NUM(4), .BUS_SIZE(32), .MEM_SIZE(128), .PREFIX_SUM_SIZE(8), .CU_NUM(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_sparsemap_i(wr_sparsemap_i), .wr_nonzero_data_i(wr_nonzero_data_i),
      .wr_bank_o(wr_bank_o), .full_cnt_o(full_cnt_o), .shift_left_i(shift_left_i),
      .pri_enc_last_i(pri_enc_last_i), .rd_sparsemap_addr_i(rd_sparsemap_addr_i),
      .rd_sparsemap_o(rd_sparsemap_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
      .rd_valid_o(rd_valid_o), .rd_bank_o(rd_bank_o)
   );

   always #5 clk_i = ~clk_i;

   // Byte pattern of a bank tagged 'tag': unique per entry, differs between tags.
   function automatic logic [7:0] pat_byte(input int tag, input int entry);
      return 8'(entry) ^ (8'h55 + 8'(tag * 16));
   endfunction

   task automatic drive_beat(input int tag, input int beat);
      wr_valid_i     = 1'b1;
      wr_sparsemap_i = smap_pat[beat];
      for (int k = 0; k < 32; k++) wr_nonzero_data_i[k*8 +: 8] = pat_byte(tag, beat * 32 + k);
      $display("beat tag=%0d idx=%0d ready=%0b bank=%0d", tag, beat, wr_ready_o, wr_bank_o);
      @(posedge clk_i); #1;
      wr_valid_i = 1'b0;
   endtask

   task automatic fill_bank(input int tag);
      for (int b = 0; b < 4; b++) drive_beat(tag, b);
   endtask

   task automatic set_seg(input int cu, input int s);
      rd_sparsemap_addr_i[cu*4 +: 4] = 4'(s);
   endtask

   task automatic set_addr(input int cu, input int a);
      rd_addr_i[cu*8 +: 8] = 8'(a);
   endtask

   task automatic test_reset();
      rst_i = 1'b0; flush_i = 1'b0; wr_valid_i = 1'b0; wr_sparsemap_i = '0; wr_nonzero_data_i = '0;
      shift_left_i = '0; pri_enc_last_i = '0; rd_sparsemap_addr_i = '0; rd_addr_i = 32'h01010101;
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++; if (wr_ready_o !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", wr_ready_o); else n_pass++;
      n_checks++; if (wr_bank_o !== 2'd0) $display("FAIL rst_wr_bank: got %0d want 0", wr_bank_o); else n_pass++;
      n_checks++; if (full_cnt_o !== 3'd0) $display("FAIL rst_full_cnt: got %0d want 0", full_cnt_o); else n_pass++;
      n_checks++; if (rd_valid_o !== 4'h0) $display("FAIL rst_rd_valid: got %h want 0", rd_valid_o); else n_pass++;
      n_checks++; if (rd_bank_o !== 8'h00) $display("FAIL rst_rd_bank: got %h want 00", rd_bank_o); else n_pass++;
      n_checks++; if (rd_sparsemap_o !== 32'h0) $display("FAIL rst_rd_smap: got %h want 0", rd_sparsemap_o); else n_pass++;
      n_checks++; if (rd_data_o !== 32'h0) $display("FAIL rst_rd_data: got %h want 0", rd_data_o); else n_pass++;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_fill_read();
      for (int b = 0; b < 4; b++) begin
         n_checks++; if (wr_ready_o !== 1'b1) $display("FAIL fill_ready_b%0d: got %b want 1", b, wr_ready_o); else n_pass++;
         drive_beat(0, b);
      end
      n_checks++; if (wr_bank_o !== 2'd1) $display("FAIL fill_wr_bank: got %0d want 1", wr_bank_o); else n_pass++;
      n_checks++; if (full_cnt_o !== 3'd1) $display("FAIL fill_full_cnt: got %0d want 1", full_cnt_o); else n_pass++;
      n_checks++; if (rd_valid_o !== 4'hF) $display("FAIL fill_rd_valid: got %h want f", rd_valid_o); else n_pass++;
      n_checks++; if (rd_bank_o !== 8'h00) $display("FAIL fill_rd_bank: got %h want 00", rd_bank_o); else n_pass++;
      set_addr(0, 1); set_addr(1, 128); set_addr(2, 129); set_addr(3, 33);
      #1;
      n_checks++; if (rd_data_o[7:0] !== 8'h55) $display("FAIL rd_addr1: got %h want 55", rd_data_o[7:0]); else n_pass++;
      n_checks++; if (rd_data_o[15:8] !== 8'h2A) $display("FAIL rd_addr128: got %h want 2a", rd_data_o[15:8]); else n_pass++;
      n_checks++; if (rd_data_o[23:16] !== 8'h00) $display("FAIL rd_addr129: got %h want 00", rd_data_o[23:16]); else n_pass++;
      n_checks++; if (rd_data_o[31:24] !== 8'h75) $display("FAIL rd_addr33: got %h want 75", rd_data_o[31:24]); else n_pass++;
      set_addr(3, 0);
      #1;
      n_checks++; if (rd_data_o[31:24] !== 8'h00) $display("FAIL rd_addr0: got %h want 00", rd_data_o[31:24]); else n_pass++;
      @(posedge clk_i); #1;
   endtask

   task automatic test_window();
      for (int r = 0; r < 4; r++) begin
         shift_left_i = 3'(win_shift[r]);
         for (int c = 0; c < 4; c++) set_seg(c, win_s[r][c]);
         #2;
         for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (rd_sparsemap_o[c*8 +: 8] !== win_exp[r][c])
               $display("FAIL window_r%0d_cu%0d: got %h want %h", r, c, rd_sparsemap_o[c*8 +: 8], win_exp[r][c]);
            else n_pass++;
         end
      end
      rd_sparsemap_addr_i = '0;
      shift_left_i = '0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_ring_full();
      fill_bank(1); fill_bank(2); fill_bank(3);
      n_checks++; if (wr_ready_o !== 1'b0) $display("FAIL ring_ready: got %b want 0", wr_ready_o); else n_pass++;
      n_checks++; if (full_cnt_o !== 3'd4) $display("FAIL ring_full_cnt: got %0d want 4", full_cnt_o); else n_pass++;
      n_checks++; if (wr_bank_o !== 2'd0) $display("FAIL ring_wr_bank: got %0d want 0", wr_bank_o); else n_pass++;
      drive_beat(9, 0);
      set_addr(0, 1);
      #1;
      n_checks++; if (wr_bank_o !== 2'd0) $display("FAIL ring_5th_wr_bank: got %0d want 0", wr_bank_o); else n_pass++;
      n_checks++; if (full_cnt_o !== 3'd4) $display("FAIL ring_5th_full_cnt: got %0d want 4", full_cnt_o); else n_pass++;
      n_checks++; if (rd_data_o[7:0] !== 8'h55) $display("FAIL ring_5th_no_overwrite: got %h want 55", rd_data_o[7:0]); else n_pass++;
   endtask

   task automatic test_staggered_release();
      rd_sparsemap_addr_i = 16'hFFFF;
      for (int c = 0; c < 3; c++) begin
         pri_enc_last_i = 4'(1 << c);
         @(posedge clk_i); #1;
         pri_enc_last_i = '0;
         n_checks++; if (full_cnt_o !== 3'd4) $display("FAIL stag_full_cnt_cu%0d: got %0d want 4", c, full_cnt_o); else n_pass++;
         n_checks++; if (wr_ready_o !== 1'b0) $display("FAIL stag_ready_cu%0d: got %b want 0", c, wr_ready_o); else n_pass++;
         n_checks++; if (rd_bank_o[c*2 +: 2] !== 2'd1) $display("FAIL stag_rd_bank_cu%0d: got %0d want 1", c, rd_bank_o[c*2 +: 2]); else n_pass++;
      end
      n_checks++; if (rd_valid_o[0] !== 1'b1) $display("FAIL stag_cu0_valid: got %b want 1", rd_valid_o[0]); else n_pass++;
      n_checks++; if (rd_data_o[7:0] !== 8'h65) $display("FAIL stag_cu0_data: got %h want 65", rd_data_o[7:0]); else n_pass++;
      pri_enc_last_i = 4'b1000;
      @(posedge clk_i); #1;
      pri_enc_last_i = '0;
      n_checks++; if (full_cnt_o !== 3'd3) $display("FAIL stag_last_full_cnt: got %0d want 3", full_cnt_o); else n_pass++;
      n_checks++; if (wr_ready_o !== 1'b1) $display("FAIL stag_last_ready: got %b want 1", wr_ready_o); else n_pass++;
      n_checks++; if (rd_bank_o !== 8'h55) $display("FAIL stag_last_rd_bank: got %h want 55", rd_bank_o); else n_pass++;
   endtask

   task automatic test_same_cycle();
      for (int b = 0; b < 3; b++) drive_beat(4, b);
      n_checks++; if (full_cnt_o !== 3'd3) $display("FAIL same_pre_full_cnt: got %0d want 3", full_cnt_o); else n_pass++;
      pri_enc_last_i = 4'hF;
      drive_beat(4, 3);
      pri_enc_last_i = '0;
      n_checks++; if (full_cnt_o !== 3'd3) $display("FAIL same_full_cnt: got %0d want 3", full_cnt_o); else n_pass++;
      n_checks++; if (wr_bank_o !== 2'd1) $display("FAIL same_wr_bank: got %0d want 1", wr_bank_o); else n_pass++;
      n_checks++; if (wr_ready_o !== 1'b1) $display("FAIL same_ready: got %b want 1", wr_ready_o); else n_pass++;
      n_checks++; if (rd_bank_o !== 8'hAA) $display("FAIL same_rd_bank: got %h want aa", rd_bank_o); else n_pass++;
      fill_bank(5);
      n_checks++; if (full_cnt_o !== 3'd4) $display("FAIL same2_pre_full_cnt: got %0d want 4", full_cnt_o); else n_pass++;
      n_checks++; if (wr_ready_o !== 1'b0) $display("FAIL same2_pre_ready: got %b want 0", wr_ready_o); else n_pass++;
      // Beat presented while its bank is being freed must not be taken.
      pri_enc_last_i = 4'hF;
      drive_beat(6, 0);
      pri_enc_last_i = '0;
      n_checks++; if (full_cnt_o !== 3'd3) $display("FAIL same2_full_cnt: got %0d want 3", full_cnt_o); else n_pass++;
      n_checks++; if (wr_ready_o !== 1'b1) $display("FAIL same2_ready: got %b want 1", wr_ready_o); else n_pass++;
      n_checks++; if (rd_bank_o !== 8'hFF) $display("FAIL same2_rd_bank: got %h want ff", rd_bank_o); else n_pass++;
      for (int b = 0; b < 3; b++) drive_beat(6, b);
      n_checks++; if (wr_bank_o !== 2'd2) $display("FAIL same2_3beats_wr_bank: got %0d want 2", wr_bank_o); else n_pass++;
      drive_beat(6, 3);
      n_checks++; if (wr_bank_o !== 2'd3) $display("FAIL same2_4beats_wr_bank: got %0d want 3", wr_bank_o); else n_pass++;
      n_checks++; if (full_cnt_o !== 3'd4) $display("FAIL same2_4beats_full_cnt: got %0d want 4", full_cnt_o); else n_pass++;
      n_checks++; if (rd_data_o[7:0] !== 8'h85) $display("FAIL same2_cu0_data: got %h want 85", rd_data_o[7:0]); else n_pass++;
   endtask

   task automatic test_flush();
      set_seg(0, 1);
      #1;
      n_checks++; if (rd_sparsemap_o[7:0] !== 8'h3C) $display("FAIL flush_pre_smap: got %h want 3c", rd_sparsemap_o[7:0]); else n_pass++;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      n_checks++; if (full_cnt_o !== 3'd0) $display("FAIL flush_full_cnt: got %0d want 0", full_cnt_o); else n_pass++;
      n_checks++; if (wr_bank_o !== 2'd0) $display("FAIL flush_wr_bank: got %0d want 0", wr_bank_o); else n_pass++;
      n_checks++; if (wr_ready_o !== 1'b1) $display("FAIL flush_ready: got %b want 1", wr_ready_o); else n_pass++;
      n_checks++; if (rd_valid_o !== 4'h0) $display("FAIL flush_rd_valid: got %h want 0", rd_valid_o); else n_pass++;
      n_checks++; if (rd_bank_o !== 8'h00) $display("FAIL flush_rd_bank: got %h want 00", rd_bank_o); else n_pass++;
      n_checks++; if (rd_sparsemap_o !== 32'h0) $display("FAIL flush_rd_smap: got %h want 0", rd_sparsemap_o); else n_pass++;
      n_checks++; if (rd_data_o !== 32'h0) $display("FAIL flush_rd_data: got %h want 0", rd_data_o); else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      fill_bank(1);
      drive_beat(1, 0); drive_beat(1, 1);
      n_checks++; if (full_cnt_o !== 3'd1) $display("FAIL midrst_pre_full_cnt: got %0d want 1", full_cnt_o); else n_pass++;
      wr_valid_i = 1'b1;
      rst_i = 1'b0;
      #1;
      n_checks++; if (wr_bank_o !== 2'd0) $display("FAIL midrst_wr_bank: got %0d want 0", wr_bank_o); else n_pass++;
      n_checks++; if (full_cnt_o !== 3'd0) $display("FAIL midrst_full_cnt: got %0d want 0", full_cnt_o); else n_pass++;
      n_checks++; if (rd_valid_o !== 4'h0) $display("FAIL midrst_rd_valid: got %h want 0", rd_valid_o); else n_pass++;
      n_checks++; if (wr_ready_o !== 1'b1) $display("FAIL midrst_ready: got %b want 1", wr_ready_o); else n_pass++;
      @(posedge clk_i); #1;
      wr_valid_i = 1'b0;
      rst_i = 1'b1;
      for (int b = 0; b < 3; b++) drive_beat(7, b);
      n_checks++; if (wr_bank_o !== 2'd0) $display("FAIL midrst_3beats_wr_bank: got %0d want 0", wr_bank_o); else n_pass++;
      drive_beat(7, 3);
      set_addr(0, 1); set_addr(3, 33);
      #1;
      n_checks++; if (wr_bank_o !== 2'd1) $display("FAIL midrst_4beats_wr_bank: got %0d want 1", wr_bank_o); else n_pass++;
      n_checks++; if (full_cnt_o !== 3'd1) $display("FAIL midrst_4beats_full_cnt: got %0d want 1", full_cnt_o); else n_pass++;
      n_checks++; if (rd_valid_o !== 4'hF) $display("FAIL midrst_rd_valid_after: got %h want f", rd_valid_o); else n_pass++;
      n_checks++; if (rd_data_o[7:0] !== 8'hC5) $display("FAIL midrst_data_e0: got %h want c5", rd_data_o[7:0]); else n_pass++;
      n_checks++; if (rd_data_o[31:24] !== 8'hE5) $display("FAIL midrst_data_e32: got %h want e5", rd_data_o[31:24]); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill_read();
      test_window();
      test_ring_full();
      test_staggered_release();
      test_same_cycle();
      test_flush();
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
